// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E/D-stage bundle between the pipeline and the multiply/divide sequencer.
interface mdu_if;

    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mt_we;
    logic        mt_sel;
    logic        d_is_md;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val,
        output mt_we, mt_sel, d_is_md,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val,
        input  mt_we, mt_sel, d_is_md,
        output stall, busy, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational mult/multu/div/divu datapath producing {hi,lo}.
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_e      i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [63:0] o_res,
    output logic        o_div_zero
);

    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_uden;
    logic [31:0] w_sden;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [63:0] w_smul;
    logic [63:0] w_umul;

    assign o_div_zero = (i_rt == 32'd0);

    assign w_rs_neg = i_rs[31];
    assign w_rt_neg = i_rt[31];
    assign w_rs_mag = w_rs_neg ? (32'd0 - i_rs) : i_rs;
    assign w_rt_mag = w_rt_neg ? (32'd0 - i_rt) : i_rt;

    // Zero divisors are replaced so the dividers never see x/0.
    assign w_uden = o_div_zero ? 32'd1 : i_rt;
    assign w_sden = o_div_zero ? 32'd1 : w_rt_mag;

    assign w_uq = i_rs / w_uden;
    assign w_ur = i_rs % w_uden;
    assign w_sq = w_rs_mag / w_sden;
    assign w_sr = w_rs_mag % w_sden;

    // Quotient truncates toward zero; remainder follows the dividend.
    assign w_q_s = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_sq) : w_sq;
    assign w_r_s = w_rs_neg ? (32'd0 - w_sr) : w_sr;

    assign w_smul = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_umul = {32'd0, i_rs} * {32'd0, i_rt};

    always_comb begin
        o_res = w_umul;
        unique case (i_op)
            MD_MULT:  o_res = w_smul;
            MD_MULTU: o_res = w_umul;
            MD_DIV:   o_res = {w_r_s, w_q_s};
            MD_DIVU:  o_res = {w_ur, w_uq};
            default:  o_res = w_umul;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner: latency-emulating FSM, pending result, mthi/mtlo and D stall.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAXC   = max_i(MULT_CYCLES, DIV_CYCLES);
    localparam int CW_RAW = $clog2(MAXC + 1);
    localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e      r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0] r_pend;
    logic        r_pend_ok;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    md_op_e      w_op;
    logic [63:0] w_res;
    logic        w_div_zero;
    logic        w_is_div;

    assign w_op     = md_op_e'(bus.md_op);
    assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);

    mdu_arith u_arith (
        .i_op       (w_op),
        .i_rs       (bus.rs_val),
        .i_rt       (bus.rt_val),
        .o_res      (w_res),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_ok <= 1'b0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_pend    <= w_res;
                        r_pend_ok <= !(w_is_div && w_div_zero);
                        r_cnt     <= w_is_div ? DIV_LD : MULT_LD;
                        r_busy    <= 1'b1;
                        r_state   <= ST_BUSY;
                    end else if (bus.mt_we) begin
                        if (bus.mt_sel) r_hi <= bus.rs_val;
                        else            r_lo <= bus.rs_val;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_pend_ok) begin
                            r_hi <= r_pend[63:32];
                            r_lo <= r_pend[31:0];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.stall = bus.d_is_md & (bus.start | r_busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized checks of mdu_ctrl against an arithmetic model.
module tb_mdu_ctrl;

    localparam int NM = 5;
    localparam int ND = 10;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_if bus ();

    mdu_ctrl #(
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the ISA definitions.
    function automatic logic [63:0] ref_md(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] h,
                                           input logic [31:0] l);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {h, l};
        case (op)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            default: if (b != 0) p = {a % b, a / b};
        endcase
        return p;
    endfunction

    task automatic mt(input logic sel, input logic [31:0] v);
        @(negedge clk);
        bus.mt_we  = 1'b1;
        bus.mt_sel = sel;
        bus.rs_val = v;
        @(negedge clk);
        bus.mt_we = 1'b0;
        if (sel) m_hi = v;
        else     m_lo = v;
        chk("mt_hi", 64'(bus.hi), 64'(m_hi));
        chk("mt_lo", 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd,
                         input logic mt_start, input logic mt_busy);
        int n;
        int lat;
        logic [63:0] e;
        lat = op[1] ? ND : NM;
        @(negedge clk);
        chk("no_start_when_busy", 64'(bus.busy), 64'd0);
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.rs_val  = a;
        bus.rt_val  = b;
        bus.d_is_md = dmd;
        bus.mt_we   = mt_start;
        bus.mt_sel  = 1'b1;
        #1;
        chk("stall_start", 64'(bus.stall), 64'(dmd));
        @(negedge clk);
        bus.start = 1'b0;
        bus.mt_we = mt_busy;
        n = 0;
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
            n++;
            vectors++;
            assert (bus.stall === dmd && bus.hi === m_hi
                    && bus.lo === m_lo) else begin
                miscompares++;
                $error("FAIL busy_cyc%0d: observed stall=%b hi=%h lo=%h expected stall=%b hi=%h lo=%h",
                       n, bus.stall, bus.hi, bus.lo, dmd, m_hi, m_lo);
            end
            @(negedge clk);
            bus.mt_we = 1'b0;
        end
        e = ref_md(op, a, b, m_hi, m_lo);
        m_hi = e[63:32];
        m_lo = e[31:0];
        chk("busy_len", 64'(n), 64'(lat));
        chk("hi", 64'(bus.hi), 64'(m_hi));
        chk("lo", 64'(bus.lo), 64'(m_lo));
        chk("stall_after", 64'(bus.stall), 64'd0);
        bus.d_is_md = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_hi        = '0;
        m_lo        = '0;
        reset       = 1'b0;
        bus.start   = 1'b1;
        bus.md_op   = 2'd0;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        bus.mt_we   = 1'b0;
        bus.mt_sel  = 1'b0;
        bus.d_is_md = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stall_start", 64'(bus.stall), 64'd1);
        bus.start = 1'b0;
        #1;
        chk("rst_stall_idle", 64'(bus.stall), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        bus.d_is_md = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        do_op(2'd0, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        chk("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFFA);
        do_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("multu_hi", 64'(bus.hi), 64'h1);
        chk("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(bus.hi), 64'h0);

        mt(1'b1, 32'h1234);
        mt(1'b0, 32'h5678);
        do_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("divz_hi", 64'(bus.hi), 64'h1234);
        chk("divz_lo", 64'(bus.lo), 64'h5678);
        do_op(2'd2, 32'h8000_0001, 32'd0, 1'b0, 1'b0, 1'b0);

        do_op(2'd0, 32'd6, 32'd7, 1'b1, 1'b0, 1'b0);
        chk("mflo_sees_new", 64'(bus.lo), 64'd42);

        mt(1'b1, 32'hDEAD_BEEF);
        chk("mthi_lo_kept", 64'(bus.lo), 64'd42);

        do_op(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
        do_op(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        bus.start  = 1'b1;
        bus.md_op  = 2'd0;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        chk("rstmid_busy", 64'(bus.busy), 64'd0);
        chk("rstmid_hi", 64'(bus.hi), 64'd0);
        chk("rstmid_lo", 64'(bus.lo), 64'd0);
        repeat (8) @(negedge clk);
        chk("rstmid_nocommit", {bus.hi, bus.lo}, 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0
              : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20))
              : 32'($urandom);
            if ($urandom_range(0, 4) == 0)
                mt(1'($urandom_range(0, 1)), a);
            else
                do_op(2'($urandom_range(0, 3)), a, b,
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
